// File: rtl/simon_pkg.sv
// Shared types for the colour game: colour codes, entry-capture states and
// helpers that turn a switch vector into a colour.
package simon_pkg;

  typedef enum logic [1:0] {
    RED    = 2'd0,
    GREEN  = 2'd1,
    BLUE   = 2'd2,
    YELLOW = 2'd3
  } colour_t;

  localparam int MAX_ROUND = 33;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_PRESS,
    ST_DB_PRESS,
    ST_WAIT_RELEASE,
    ST_DB_RELEASE,
    ST_DONE
  } entry_state_t;

  function automatic logic is_onehot(input logic [3:0] v);
    return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction

  function automatic colour_t encode_colour(input logic [3:0] v);
    colour_t c;
    c = RED;
    for (int i = 0; i < 4; i++) begin
      if (v[i]) c = colour_t'(i[1:0]);
    end
    return c;
  endfunction

endpackage

// File: rtl/player_entry_capture_if.sv
// Bundle between the game controller and the player entry capture block.
interface player_entry_capture_if #(
  parameter int IDX_W = 6
);
  logic             player_turn;
  logic [IDX_W-1:0] round_len;
  logic [3:0]       player_input;
  logic [1:0]       colour_o;
  logic             colour_valid;
  logic [IDX_W-1:0] entry_idx;
  logic             done;
  logic             timeout;
  logic             multi_err;

  modport master (
    output player_turn, round_len, player_input,
    input  colour_o, colour_valid, entry_idx, done, timeout, multi_err
  );

  modport slave (
    input  player_turn, round_len, player_input,
    output colour_o, colour_valid, entry_idx, done, timeout, multi_err
  );
endinterface

// File: rtl/player_entry_capture_debounce_vec.sv
// Two-flop synchroniser plus a shared stability counter for a switch vector.
// changed pulses once each time a vector has been held for CYCLES samples.
module debounce_vec #(
  parameter int W      = 4,
  parameter int CYCLES = 500_000
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] raw,
  output logic [W-1:0] synced,
  output logic [W-1:0] stable,
  output logic         changed
);
  localparam int              CNT_W   = $clog2(CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CYCLES);

  logic [W-1:0]     sw_p0, sw_p1, cand;
  logic [CNT_W-1:0] cnt;

  // Counter starts saturated so the all-zero reset value is not re-announced.
  always_ff @(posedge clk) begin
    if (reset) begin
      sw_p0   <= '0;
      sw_p1   <= '0;
      cand    <= '0;
      cnt     <= CNT_MAX;
      stable  <= '0;
      changed <= 1'b0;
    end else begin
      sw_p0   <= raw;
      sw_p1   <= sw_p0;
      changed <= 1'b0;
      if (sw_p1 != cand) begin
        cand <= sw_p1;
        cnt  <= CNT_W'(1);
      end else if (cnt != CNT_MAX) begin
        cnt <= cnt + CNT_W'(1);
        if (cnt == CNT_MAX - CNT_W'(1)) begin
          stable  <= cand;
          changed <= 1'b1;
        end
      end
    end
  end

  assign synced = sw_p1;

endmodule

// File: rtl/player_entry_capture.sv
// Player reply capture: debounced one-hot switch presses become colour entries,
// with timeout, multi-switch and round-complete pulses for the game FSM.
module player_entry_capture
  import simon_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500_000,
  parameter int TIMEOUT_CYCLES  = 150_000_000,
  parameter int IDX_W           = 6
) (
  input  logic                   clk,
  input  logic                   reset,
  player_entry_capture_if.slave  bus
);
  localparam int               TIM_W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [TIM_W-1:0] TIM_LAST = TIM_W'(TIMEOUT_CYCLES - 1);

  entry_state_t     state, state_n;
  logic             turn_q;
  logic [TIM_W-1:0] timer, timer_n;
  logic [IDX_W-1:0] idx, idx_n, rlen, rlen_n;
  logic [1:0]       colour_n;
  logic             valid_n, done_n, timeout_n, merr_n;
  logic [3:0]       synced, stable;
  logic             changed;

  function automatic logic [IDX_W-1:0] sat_idx_inc(input logic [IDX_W-1:0] v,
                                                   input logic [IDX_W-1:0] lim);
    return (v < lim) ? v + IDX_W'(1) : v;
  endfunction

  function automatic logic [TIM_W-1:0] sat_timer_inc(input logic [TIM_W-1:0] v);
    return (v == TIM_LAST) ? v : v + TIM_W'(1);
  endfunction

  debounce_vec #(
    .W      (4),
    .CYCLES (DEBOUNCE_CYCLES)
  ) u_db (
    .clk     (clk),
    .reset   (reset),
    .raw     (bus.player_input),
    .synced  (synced),
    .stable  (stable),
    .changed (changed)
  );

  always_comb begin
    state_n   = state;
    timer_n   = timer;
    idx_n     = idx;
    rlen_n    = rlen;
    colour_n  = 2'd0;
    valid_n   = 1'b0;
    done_n    = 1'b0;
    timeout_n = 1'b0;
    merr_n    = 1'b0;
    if (!bus.player_turn) begin
      state_n = ST_IDLE;
      timer_n = '0;
      idx_n   = '0;
      rlen_n  = '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (!turn_q) begin
            rlen_n  = bus.round_len;
            idx_n   = '0;
            timer_n = '0;
            // A switch already held at round start must be released first.
            if (bus.round_len == '0)  state_n = ST_DONE;
            else if (synced != 4'd0)  state_n = ST_WAIT_RELEASE;
            else                      state_n = ST_WAIT_PRESS;
          end
        end
        ST_WAIT_PRESS: begin
          if (synced != 4'd0) begin
            timer_n = sat_timer_inc(timer);
            state_n = ST_DB_PRESS;
          end else if (timer == TIM_LAST) begin
            timeout_n = 1'b1;
            state_n   = ST_IDLE;
          end else begin
            timer_n = sat_timer_inc(timer);
          end
        end
        ST_DB_PRESS: begin
          timer_n = sat_timer_inc(timer);
          if (changed && stable != 4'd0) begin
            if (is_onehot(stable)) begin
              valid_n  = 1'b1;
              colour_n = encode_colour(stable);
              idx_n    = sat_idx_inc(idx, rlen);
            end else begin
              merr_n = 1'b1;
            end
            state_n = ST_WAIT_RELEASE;
          end else if (synced == 4'd0) begin
            state_n = ST_WAIT_PRESS;
          end
        end
        ST_WAIT_RELEASE: begin
          if (synced == 4'd0) state_n = ST_DB_RELEASE;
        end
        ST_DB_RELEASE: begin
          if (changed && stable == 4'd0) begin
            if (idx == rlen) begin
              done_n  = 1'b1;
              state_n = ST_DONE;
            end else begin
              timer_n = '0;
              state_n = ST_WAIT_PRESS;
            end
          end else if (synced != 4'd0) begin
            state_n = ST_WAIT_RELEASE;
          end
        end
        ST_DONE: state_n = ST_DONE;
        default: state_n = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= ST_IDLE;
      turn_q           <= 1'b0;
      timer            <= '0;
      idx              <= '0;
      rlen             <= '0;
      bus.colour_o     <= 2'd0;
      bus.colour_valid <= 1'b0;
      bus.done         <= 1'b0;
      bus.timeout      <= 1'b0;
      bus.multi_err    <= 1'b0;
    end else begin
      state            <= state_n;
      turn_q           <= bus.player_turn;
      timer            <= timer_n;
      idx              <= idx_n;
      rlen             <= rlen_n;
      bus.colour_o     <= colour_n;
      bus.colour_valid <= valid_n;
      bus.done         <= done_n;
      bus.timeout      <= timeout_n;
      bus.multi_err    <= merr_n;
    end
  end

  assign bus.entry_idx = idx;

endmodule
